stream_dest_router: RTL

Egress half of the streaming crossbar. Takes one slave stream (the arbitrated output of the round-robin stage: data, last, id, valid) plus a destination field, and steers whole packets to one of M_DATA_COUNT master ports.
- Route locked on the first beat of a packet, held until the last beat is accepted.
- One registered output slice per master port.
- Packets with an out-of-range destination are consumed, discarded and counted.

---
 rtl/stream_dest_router_pkg.sv | 10 +
 rtl/stream_reg_slice.sv | 35 +++
 rtl/stream_dest_router.sv | 74 +++++++
 3 files changed

// File: rtl/stream_dest_router_pkg.sv
// stream_dest_router_pkg: shared crossbar defaults, width derivations and egress FSM encoding
package stream_dest_router_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_S_COUNT = 5;
  localparam int DEF_M_COUNT = 3;
  localparam int DEF_ID_WIDTH = $clog2(DEF_S_COUNT);
  localparam int DEF_DEST_WIDTH = $clog2(DEF_M_COUNT);
  localparam int DROP_CNT_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_e;
endpackage

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: single-entry valid/ready output register carrying data, last and id
module stream_reg_slice #(
  parameter int DW = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  input  logic [IW-1:0] s_id,
  input  logic          m_ready,
  output logic          slot_rdy,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [IW-1:0] m_id
);
  assign slot_rdy = !m_valid | m_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_last  <= s_last;
      m_id    <= s_id;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_dest_router.sv
// stream_dest_router: steers whole packets to a master port chosen on the first beat;
// out-of-range destinations are swallowed and counted.
module stream_dest_router
  import stream_dest_router_pkg::*;
#(
  parameter int T_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int S_DATA_COUNT = DEF_S_COUNT,
  parameter int M_DATA_COUNT = DEF_M_COUNT,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [T_DATA_WIDTH-1:0]              s_data_i,
  input  logic                                 s_valid_i,
  input  logic                                 s_last_i,
  input  logic [T_ID___WIDTH-1:0]              s_id_i,
  input  logic [T_DEST_WIDTH-1:0]              s_dest_i,
  output logic                                 s_ready_o,
  output logic [M_DATA_COUNT*T_DATA_WIDTH-1:0] m_data_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [DROP_CNT_W-1:0]                drop_cnt_o
);
  localparam logic [T_DEST_WIDTH:0] DEST_LIM = (T_DEST_WIDTH+1)'(M_DATA_COUNT);
  state_e state_q, state_d;
  logic [T_DEST_WIDTH-1:0] route_q, sel;
  logic [M_DATA_COUNT-1:0] slot_rdy, load;
  logic dest_ok, drop_mode, sel_rdy, accept;
  assign dest_ok = {1'b0, s_dest_i} < DEST_LIM;
  assign drop_mode = state_q == DROP || (state_q == IDLE && !dest_ok);
  assign sel = state_q == IDLE ? s_dest_i : route_q;
  always_comb begin
    sel_rdy = 1'b0;
    for (int i = 0; i < M_DATA_COUNT; i++)
      if (sel == T_DEST_WIDTH'(i)) sel_rdy = slot_rdy[i];
  end
  assign s_ready_o = drop_mode | sel_rdy;
  assign accept = s_valid_i & s_ready_o;
  always_comb begin
    state_d = state_q;
    if (accept) state_d = s_last_i ? IDLE : state_q != IDLE ? state_q : dest_ok ? PASS : DROP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      route_q    <= '0;
      drop_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == IDLE && dest_ok) route_q <= s_dest_i;
      if (accept && state_q == IDLE && !dest_ok && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
  for (genvar k = 0; k < M_DATA_COUNT; k++) begin : g_port
    assign load[k] = accept && !drop_mode && sel == T_DEST_WIDTH'(k);
    stream_reg_slice #(.DW(T_DATA_WIDTH), .IW(T_ID___WIDTH)) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .s_data   (s_data_i),
      .s_last   (s_last_i),
      .s_id     (s_id_i),
      .m_ready  (m_ready_i[k]),
      .slot_rdy (slot_rdy[k]),
      .m_valid  (m_valid_o[k]),
      .m_data   (m_data_o[k*T_DATA_WIDTH +: T_DATA_WIDTH]),
      .m_last   (m_last_o[k]),
      .m_id     (m_id_o[k*T_ID___WIDTH +: T_ID___WIDTH])
    );
  end
endmodule
